// File: rtl/coherence_pkg.sv
// Shared definitions for the snooping coherence bus: line states, bus ops, controller FSM states.
package coherence_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned IDX_W = 2;

   localparam logic [1:0] LS_INVALID   = 2'b00;
   localparam logic [1:0] LS_SHARED    = 2'b01;
   localparam logic [1:0] LS_EXCLUSIVE = 2'b10;

   localparam logic [OP_W-1:0] BUS_IDLE       = 3'b000;
   localparam logic [OP_W-1:0] BUS_RD_MISS    = 3'b001;
   localparam logic [OP_W-1:0] BUS_WR_MISS    = 3'b010;
   localparam logic [OP_W-1:0] BUS_INVALIDATE = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BCAST,
      ST_MEMRD,
      ST_WB,
      ST_RESP
   } state_t;

   // Only real bus transactions compete for the bus; any other op code is ignored.
   function automatic logic is_bus_req(input logic [OP_W-1:0] op);
      return (op == BUS_RD_MISS) || (op == BUS_WR_MISS) || (op == BUS_INVALIDATE);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
   import coherence_pkg::*;
#(
   parameter int unsigned NPROC = 3
) (
   input  logic [NPROC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NPROC-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   localparam int unsigned SEL_W = (NPROC > 1) ? $clog2(NPROC) : 1;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int unsigned k = 0; k < NPROC; k++) begin
         if (!valid && req[SEL_W'((32'(ptr) + k) % NPROC)]) begin
            gnt[SEL_W'((32'(ptr) + k) % NPROC)] = 1'b1;
            idx   = IDX_W'((32'(ptr) + k) % NPROC);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Shared snooping-bus controller: arbitrates cache misses, broadcasts them, and
// completes each one from a snooper writeback or from memory.
module snoop_bus_ctrl
   import coherence_pkg::*;
#(
   parameter int unsigned NPROC  = 3,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NPROC-1:0]         req,
   input  logic [OP_W*NPROC-1:0]    req_op,
   input  logic [ADDR_W*NPROC-1:0]  req_addr,
   output logic [NPROC-1:0]         grant,
   output logic [OP_W-1:0]          bus,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [IDX_W-1:0]         bus_src,
   input  logic                     snoop_writeback,
   input  logic                     snoop_abort,
   input  logic [DATA_W-1:0]        snoop_data,
   output logic                     mem_rd_en,
   output logic                     mem_wr_en,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ready,
   output logic                     resp_valid,
   output logic [IDX_W-1:0]         resp_proc,
   output logic [DATA_W-1:0]        resp_data
);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   lat_src;
   logic [OP_W-1:0]    lat_op;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_data;

   logic [NPROC-1:0]   elig;
   logic [OP_W-1:0]    op_arr   [NPROC];
   logic [ADDR_W-1:0]  addr_arr [NPROC];
   logic [NPROC-1:0]   arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   // Unpack per-cache slices and qualify requests by op code.
   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(NPROC); i++) begin
         op_arr[i]   = req_op[OP_W*i +: OP_W];
         addr_arr[i] = req_addr[ADDR_W*i +: ADDR_W];
         elig[i]     = req[i] && is_bus_req(op_arr[i]);
      end
   end

   rr_arbiter #(.NPROC(NPROC)) u_arb (
      .req   (elig),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         lat_src    <= '0;
         lat_op     <= BUS_IDLE;
         lat_addr   <= '0;
         lat_data   <= '0;
         grant      <= '0;
         bus        <= BUS_IDLE;
         bus_addr   <= '0;
         bus_src    <= '0;
         mem_rd_en  <= 1'b0;
         mem_wr_en  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_proc  <= '0;
         resp_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  lat_src  <= arb_idx;
                  lat_op   <= op_arr[arb_idx];
                  lat_addr <= addr_arr[arb_idx];
                  grant    <= arb_gnt;
                  bus      <= op_arr[arb_idx];
                  bus_addr <= addr_arr[arb_idx];
                  bus_src  <= arb_idx;
                  ptr      <= (32'(arb_idx) + 1 == NPROC) ? '0 : arb_idx + IDX_W'(1);
                  state    <= ST_BCAST;
               end
            end
            // Snooper answers are combinational from bus, so they are valid at the end of this cycle.
            ST_BCAST: begin
               bus      <= BUS_IDLE;
               bus_addr <= '0;
               bus_src  <= '0;
               lat_data <= snoop_data;
               if (lat_op == BUS_INVALIDATE) begin
                  resp_valid <= 1'b1;
                  resp_proc  <= lat_src;
                  resp_data  <= '0;
                  state      <= ST_RESP;
               end else if (snoop_abort || snoop_writeback) begin
                  mem_wr_en <= 1'b1;
                  mem_addr  <= lat_addr;
                  mem_wdata <= snoop_data;
                  state     <= ST_WB;
               end else begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= lat_addr;
                  state     <= ST_MEMRD;
               end
            end
            ST_WB: begin
               if (mem_ready) begin
                  mem_wr_en  <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
                  resp_valid <= 1'b1;
                  resp_proc  <= lat_src;
                  resp_data  <= lat_data;
                  state      <= ST_RESP;
               end
            end
            ST_MEMRD: begin
               if (mem_ready) begin
                  mem_rd_en  <= 1'b0;
                  mem_addr   <= '0;
                  resp_valid <= 1'b1;
                  resp_proc  <= lat_src;
                  resp_data  <= mem_rdata;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               grant      <= '0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and data return.
module tb_snoop_bus_ctrl;

   logic        clock;
   logic        reset_n;
   logic [2:0]  req;
   logic [8:0]  req_op;
   logic [23:0] req_addr;
   logic [2:0]  grant;
   logic [2:0]  bus;
   logic [7:0]  bus_addr;
   logic [1:0]  bus_src;
   logic        snoop_writeback;
   logic        snoop_abort;
   logic [7:0]  snoop_data;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic        resp_valid;
   logic [1:0]  resp_proc;
   logic [7:0]  resp_data;

   int checks   = 0;
   int failures = 0;

   // Model: what each cache is asking for, and where round-robin search starts.
   bit          rq  [3];
   logic [2:0]  rop [3];
   logic [7:0]  rad [3];
   int          mptr;

   snoop_bus_ctrl #(.NPROC(3), .ADDR_W(8), .DATA_W(8)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req             (req),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .grant           (grant),
      .bus             (bus),
      .bus_addr        (bus_addr),
      .bus_src         (bus_src),
      .snoop_writeback (snoop_writeback),
      .snoop_abort     (snoop_abort),
      .snoop_data      (snoop_data),
      .mem_rd_en       (mem_rd_en),
      .mem_wr_en       (mem_wr_en),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_ready       (mem_ready),
      .resp_valid      (resp_valid),
      .resp_proc       (resp_proc),
      .resp_data       (resp_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"},  32'(grant),      32'd0);
      chk({tag, "_bus"},    32'(bus),        32'd0);
      chk({tag, "_baddr"},  32'(bus_addr),   32'd0);
      chk({tag, "_bsrc"},   32'(bus_src),    32'd0);
      chk({tag, "_rd_en"},  32'(mem_rd_en),  32'd0);
      chk({tag, "_wr_en"},  32'(mem_wr_en),  32'd0);
      chk({tag, "_maddr"},  32'(mem_addr),   32'd0);
      chk({tag, "_wdata"},  32'(mem_wdata),  32'd0);
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_rproc"},  32'(resp_proc),  32'd0);
      chk({tag, "_rdata"},  32'(resp_data),  32'd0);
   endtask

   task automatic drive_reqs();
      req      = {rq[2] ? 1'b1 : 1'b0, rq[1] ? 1'b1 : 1'b0, rq[0] ? 1'b1 : 1'b0};
      req_op   = {rop[2], rop[1], rop[0]};
      req_addr = {rad[2], rad[1], rad[0]};
   endtask

   function automatic bit model_elig(input int c);
      return rq[c] && (rop[c] == 3'b001 || rop[c] == 3'b010 || rop[c] == 3'b011);
   endfunction

   // Run one transaction starting in an IDLE cycle with requests already driven.
   // smode: 0 no owner, 1 abort+writeback, 2 abort only, 3 writeback only.
   task automatic run_txn(input int stall, input int smode, input logic [7:0] sdata,
                          input logic [7:0] rdata, input bit drop, output int src);
      int  w;
      bit  wbpath;
      w = -1;
      for (int k = 0; k < 3; k++)
         if (w < 0 && model_elig((mptr + k) % 3)) w = (mptr + k) % 3;
      if (w < 0) begin
         checks++;
         failures++;
         $error("FAIL no_eligible observed=none expected=one");
         src = -1;
         return;
      end
      mptr = (w + 1) % 3;

      tick();
      chk("bcast_grant", 32'(grant),      32'(1) << w);
      chk("bcast_bus",   32'(bus),        32'(rop[w]));
      chk("bcast_addr",  32'(bus_addr),   32'(rad[w]));
      chk("bcast_src",   32'(bus_src),    32'(w));
      chk("bcast_rv",    32'(resp_valid), 32'd0);
      chk("bcast_mem",   32'({mem_rd_en, mem_wr_en}), 32'd0);
      src = int'(bus_src);

      snoop_abort     = (smode == 1 || smode == 2);
      snoop_writeback = (smode == 1 || smode == 3);
      snoop_data      = sdata;
      tick();
      snoop_abort     = 1'b0;
      snoop_writeback = 1'b0;
      snoop_data      = ~sdata;
      chk("post_bus",   32'(bus),   32'd0);
      chk("post_grant", 32'(grant), 32'(1) << w);

      if (rop[w] == 3'b011) begin
         chk("inv_rv",    32'(resp_valid), 32'd1);
         chk("inv_proc",  32'(resp_proc),  32'(w));
         chk("inv_data",  32'(resp_data),  32'd0);
         chk("inv_mem",   32'({mem_rd_en, mem_wr_en}), 32'd0);
      end else begin
         wbpath = (smode != 0);
         chk("mem_wr_en", 32'(mem_wr_en), 32'(wbpath));
         chk("mem_rd_en", 32'(mem_rd_en), 32'(!wbpath));
         chk("mem_addr",  32'(mem_addr),  32'(rad[w]));
         if (wbpath) chk("mem_wdata", 32'(mem_wdata), 32'(sdata));
         for (int s = 0; s < stall; s++) begin
            mem_rdata = 8'($urandom);
            tick();
            chk("stall_en", 32'({mem_rd_en, mem_wr_en}), wbpath ? 32'd1 : 32'd2);
            chk("stall_rv", 32'(resp_valid), 32'd0);
         end
         mem_ready = 1'b1;
         mem_rdata = rdata;
         tick();
         mem_ready = 1'b0;
         mem_rdata = 8'($urandom);
         chk("resp_rv",   32'(resp_valid), 32'd1);
         chk("resp_proc", 32'(resp_proc),  32'(w));
         chk("resp_data", 32'(resp_data),  wbpath ? 32'(sdata) : 32'(rdata));
         chk("resp_mem",  32'({mem_rd_en, mem_wr_en}), 32'd0);
         chk("resp_grant", 32'(grant), 32'(1) << w);
      end

      if (drop) rq[w] = 1'b0;
      drive_reqs();
      tick();
      chk("idle_rv",    32'(resp_valid), 32'd0);
      chk("idle_grant", 32'(grant),      32'd0);
   endtask

   initial begin
      int src;
      int exp_order [4];
      exp_order = '{0, 1, 2, 0};
      reset_n = 1'b0;
      snoop_writeback = 1'b0;
      snoop_abort = 1'b0;
      snoop_data = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rq[c] = 1'b0; rop[c] = 3'b000; rad[c] = 8'h00;
      end
      mptr = 0;
      drive_reqs();
      tick();
      tick();
      chk_zero("reset");
      reset_n = 1'b1;
      tick();
      chk("idle_after_reset", 32'(grant), 32'd0);

      // Ineligible op codes are never granted.
      rq[1] = 1'b1; rop[1] = 3'b100; rad[1] = 8'h44;
      drive_reqs();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("badop_grant", 32'(grant), 32'd0);
         chk("badop_bus",   32'(bus),   32'd0);
      end
      rop[1] = 3'b000;
      drive_reqs();
      tick();
      chk("op0_grant", 32'(grant), 32'd0);
      rq[1] = 1'b0;
      drive_reqs();
      tick();

      // Read miss, no owner.
      rq[0] = 1'b1; rop[0] = 3'b001; rad[0] = 8'h12;
      drive_reqs();
      run_txn(0, 0, 8'h00, 8'hA5, 1'b1, src);

      // Read miss serviced by an exclusive owner's writeback.
      rq[0] = 1'b1; rop[0] = 3'b001; rad[0] = 8'h12;
      drive_reqs();
      run_txn(0, 1, 8'h3C, 8'h99, 1'b1, src);

      // Invalidate from cache 2.
      rq[2] = 1'b1; rop[2] = 3'b011; rad[2] = 8'h20;
      drive_reqs();
      run_txn(0, 0, 8'h00, 8'h00, 1'b1, src);

      // Fairness with all three requests held.
      for (int c = 0; c < 3; c++) begin
         rq[c] = 1'b1; rop[c] = 3'b001; rad[c] = 8'(8'h30 + c);
      end
      drive_reqs();
      for (int i = 0; i < 4; i++) begin
         run_txn(0, 0, 8'h00, 8'(8'h50 + i), 1'b0, src);
         chk("rr_order", 32'(src), 32'(exp_order[i]));
      end
      for (int c = 0; c < 3; c++) rq[c] = 1'b0;
      drive_reqs();
      tick();

      // Memory stall of four cycles on a write miss.
      rq[1] = 1'b1; rop[1] = 3'b010; rad[1] = 8'h6E;
      drive_reqs();
      run_txn(4, 0, 8'h00, 8'hC7, 1'b1, src);

      // Writeback with only snoop_writeback asserted, plus a stall.
      rq[0] = 1'b1; rop[0] = 3'b010; rad[0] = 8'h81;
      drive_reqs();
      run_txn(2, 3, 8'h5A, 8'h11, 1'b1, src);

      // Reset in the middle of a writeback.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      mptr = 0;
      tick();
      rq[1] = 1'b1; rop[1] = 3'b001; rad[1] = 8'h66;
      rq[2] = 1'b1; rop[2] = 3'b010; rad[2] = 8'h77;
      drive_reqs();
      tick();
      chk("wbrst_grant", 32'(grant),   32'b010);
      chk("wbrst_src",   32'(bus_src), 32'd1);
      snoop_abort = 1'b1; snoop_writeback = 1'b1; snoop_data = 8'h3C;
      tick();
      snoop_abort = 1'b0; snoop_writeback = 1'b0; snoop_data = 8'h00;
      chk("wbrst_wr_en", 32'(mem_wr_en), 32'd1);
      chk("wbrst_wdata", 32'(mem_wdata), 32'h3C);
      tick();
      chk("wbrst_hold",  32'(mem_wr_en), 32'd1);
      reset_n = 1'b0;
      tick();
      chk_zero("wbrst");
      reset_n = 1'b1;
      mptr = 0;
      run_txn(0, 0, 8'h00, 8'hE1, 1'b1, src);
      chk("wbrst_regrant", 32'(src), 32'd1);
      run_txn(1, 2, 8'hB4, 8'h00, 1'b1, src);

      // Random traffic against the model.
      for (int t = 0; t < 60; t++) begin
         bit any;
         for (int c = 0; c < 3; c++) begin
            if (!model_elig(c) && $urandom_range(0, 1) == 1) begin
               int r;
               r = int'($urandom_range(0, 9));
               rq[c]  = 1'b1;
               rop[c] = (r < 7) ? 3'((r % 3) + 1) : 3'($urandom_range(4, 7));
               rad[c] = 8'($urandom);
            end
         end
         any = 1'b0;
         for (int c = 0; c < 3; c++) if (model_elig(c)) any = 1'b1;
         if (!any) begin
            rq[0] = 1'b1; rop[0] = 3'b001; rad[0] = 8'($urandom);
         end
         drive_reqs();
         run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), 1'b1, src);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
- Shared-bus controller for the snooping coherence system; sits downstream of each cache's processor-side miss logic and upstream of the per-cache snoop state machines.
- Arbitrates bus requests from NPROC caches and broadcasts the winner's op/address/index on the bus.
- Consumes the snoopers' writeback_block/abort_mem_accs/data_out: either writes back the dirty block and forwards it, or reads memory, then returns data to the requester.

Parameters:
NPROC, 3, number of caches (1..4; index is 2 bits)
ADDR_W, 8, block address width
DATA_W, 8, block data width

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  reset; synchronous, active-low
req  in  NPROC  per-cache bus request; held until its resp_valid
req_op  in  3*NPROC  per-cache op; slice i = bits [3i+2:3i]
req_addr  in  ADDR_W*NPROC  per-cache block address, same slicing
grant  out  NPROC  one-hot, current bus owner
bus  out  3  broadcast op: 000 idle, 001 read miss, 010 write miss, 011 invalidate
bus_addr  out  ADDR_W  broadcast address
bus_src  out  2  broadcast requester index
snoop_writeback  in  1  OR of all snoopers' writeback_block
snoop_abort  in  1  OR of all snoopers' abort_mem_accs
snoop_data  in  DATA_W  data from the owning snooper
mem_rd_en  out  1  memory read request
mem_wr_en  out  1  memory write request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
resp_valid  out  1  one-cycle response strobe
resp_proc  out  2  index of the responded cache
resp_data  out  DATA_W  block data; 0 for invalidate

Behaviour:
- All outputs registered. Reset (reset_n=0 at an edge) clears every output to 0, sets FSM to IDLE and round-robin pointer to 0. This applies mid-transaction: mem enables drop at that edge, and the transaction is lost.
- Eligible request: req[i]=1 and req_op slice in {001,010,011}. Other op codes are never granted.
- Round-robin arbitration: search starts at pointer and wraps. After a grant, pointer = winner+1 mod NPROC.
- FSM states: IDLE, BCAST, MEMRD, WB, RESP.
- IDLE:
  - Outputs bus=000, grant=0.
  - If any request is eligible: latch winner index, op and addr; set grant; go to BCAST.
- BCAST (exactly 1 cycle):
  - Drive bus/bus_addr/bus_src from latched values.
  - At the end of the cycle, sample snoop_writeback, snoop_abort and snoop_data, which snoopers derive combinationally from bus.
  - Next state: op=011 -> RESP; snoop_abort=1 -> WB; else -> MEMRD.
- After BCAST: bus returns to 000; grant stays asserted through RESP.
- WB:
  - mem_wr_en=1, mem_addr=latched addr, mem_wdata=latched snoop_data. Hold until mem_ready.
  - On mem_ready: resp_data <= snoop_data; go to RESP. The memory read is suppressed.
- snoop_writeback=1 with snoop_abort=0: treated as WB (protocol error tolerated).
- MEMRD: mem_rd_en=1, mem_addr=latched addr until mem_ready. On mem_ready: resp_data <= mem_rdata; go to RESP.
- RESP:
  - resp_valid=1 for one cycle, with resp_proc=latched index.
  - Invalidate responds with data 0.
  - Next cycle: grant=0, resp_valid=0, state IDLE. The freed cache may request again from that IDLE cycle.
- Latency: request sampled in IDLE at cycle N.
  - Read/write miss, no abort, mem_ready on first MEMRD cycle: resp_valid at cycle N+3.
  - Invalidate: resp_valid at cycle N+2.
  - Each mem_ready wait cycle adds 1.
- Requests arriving while busy wait; no queueing beyond req hold. Dropping req mid-transaction does not abort the transaction.
- Simultaneous requests: one grant per transaction; the others wait in round-robin order.

Decomposition:
- coherence_pkg: line-state constants (INVALID 00, SHARED 01, EXCLUSIVE 10), bus op constants (IDLE 000, RD_MISS 001, WR_MISS 010, INVALIDATE 011), FSM state typedef.
- Sub-module rr_arbiter: NPROC request vector plus pointer in; one-hot grant and index out; combinational; pointer update stays in the parent.

Test Plan:
- Read miss, no owner: req[0]=1, op=001, addr=0x12, mem_ready on first MEMRD cycle with mem_rdata=0xA5 -> bus=001/0x12/src 0 for one cycle; resp_valid at N+3, resp_proc=0, resp_data=0xA5; mem_wr_en never asserted.
- Read miss hits exclusive owner: snoop_abort=snoop_writeback=1, snoop_data=0x3C during BCAST -> mem_wr_en with addr 0x12, wdata 0x3C; mem_rd_en never asserted; resp_data=0x3C.
- Invalidate: req[2]=1, op=011 -> one bus cycle; no memory access; resp_valid at N+2, resp_proc=2, resp_data=0.
- Arbitration fairness: req=3'b111, all held -> grant order 0,1,2,0; bus_src matches each grant.
- Memory stall: mem_ready low 4 cycles in MEMRD -> mem_rd_en held 5 cycles; resp_valid at N+7.
- Reset mid-WB: reset_n=0 during WB -> next edge all outputs 0, state IDLE; held req[1] re-granted first after reset release since the pointer resets to 0 and req[0]=0.
